up_data_demux: RTL

Receive-side counterpart of the four-channel FIFO aggregator. It consumes the 64-bit `up_data` word stream qualified by `data_valid` and checks each word's framing header. Accepted 32-bit payloads are routed back to four per-channel outputs, while sequence continuity and checksum errors are tracked. It sits on the `fifo_rdclk` domain at the far end of the uplink and drives the per-channel consumers.

---
 rtl/up_data_pkg.sv | 41 ++++
 rtl/up_data_demux_seq.sv | 35 +++
 rtl/up_data_demux.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/up_data_pkg.sv
// up_data_pkg: shared definitions for the uplink receive demux.
//   - bit positions of the 64-bit up_data word fields
//   - default header sync byte
//   - lock FSM state type, channel id type, S1->S2 decode record
//   - payload_xor(): byte-wise XOR checksum of a 32-bit payload
package up_data_pkg;

  localparam int SYNC_MSB = 63;
  localparam int SYNC_LSB = 56;
  localparam int CH_MSB   = 55;
  localparam int CH_LSB   = 54;
  localparam int RSV_MSB  = 53;
  localparam int RSV_LSB  = 48;
  localparam int SEQ_MSB  = 47;
  localparam int SEQ_LSB  = 40;
  localparam int CHK_MSB  = 39;
  localparam int CHK_LSB  = 32;
  localparam int PL_MSB   = 31;
  localparam int PL_LSB   = 0;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int         NUM_CH        = 4;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;

  typedef logic [1:0] ch_id_t;

  // Decoded word handed from S1 to S2.
  typedef struct packed {
    logic        hdr_ok;
    logic        chk_ok;
    ch_id_t      ch;
    logic [7:0]  seq;
    logic [31:0] payload;
  } dec_t;

  function automatic logic [7:0] payload_xor(input logic [31:0] p);
    return p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction

endpackage

// File: rtl/up_data_demux_seq.sv
// up_seq_tracker: per-channel sequence continuity tracker.
//   fifo_rdclk, rst_n : clock, async active-low reset
//   acc               : a word for this channel is being delivered
//   clr               : lock just acquired; forget the expected value
//   seq               : sequence number of the delivered word
//   seq_err           : combinational, high when an initialised tracker sees
//                       an unexpected seq on an accepted word
module up_seq_tracker (
  input  logic       fifo_rdclk,
  input  logic       rst_n,
  input  logic       acc,
  input  logic       clr,
  input  logic [7:0] seq,
  output logic       seq_err
);

  logic [7:0] expected;
  logic       init;

  assign seq_err = acc && init && (seq != expected);

  // Always resync to seq+1 so a single gap costs one error, not a stream.
  always_ff @(posedge fifo_rdclk or negedge rst_n) begin
    if (!rst_n) begin
      expected <= '0;
      init     <= 1'b0;
    end else if (clr) begin
      init     <= 1'b0;
    end else if (acc) begin
      init     <= 1'b1;
      expected <= seq + 8'd1;
    end
  end

endmodule

// File: rtl/up_data_demux.sv
// up_data_demux: receive-side demux for the 4-channel uplink word stream.
//   fifo_rdclk, rst_n      : clock, async active-low reset
//   data_valid, up_data    : incoming 64-bit framed words
//   chN_valid / chN_data   : per-channel payload strobe / held payload
//   sync_lock              : lock FSM is LOCKED
//   hdr_err/chk_err/seq_err: one-cycle error pulses
//   err_cnt                : saturating count of words with any error
// Optional: UP_DEMUX_CHKSUM_EN enables the payload XOR check; without it the
// checksum byte is ignored and chk_err stays 0.
// Pipeline: S1 captures the word and decodes it, S2 runs the FSM/trackers and
// registers outputs; a word sampled at edge T shows its outputs after T+2.
module up_data_demux
  import up_data_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int unsigned LOCK_GOOD = 2,
  parameter int unsigned LOCK_BAD  = 4
) (
  input  logic        fifo_rdclk,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic [63:0] up_data,
  output logic        ch1_valid,
  output logic        ch2_valid,
  output logic        ch3_valid,
  output logic        ch4_valid,
  output logic [31:0] ch1_data,
  output logic [31:0] ch2_data,
  output logic [31:0] ch3_data,
  output logic [31:0] ch4_data,
  output logic        sync_lock,
  output logic        hdr_err,
  output logic        chk_err,
  output logic        seq_err,
  output logic [15:0] err_cnt
);

  localparam logic [7:0] LG = 8'(LOCK_GOOD);
  localparam logic [7:0] LB = 8'(LOCK_BAD);

  logic [2:1]  vld_pipe;
  logic [63:0] s1_word;
  dec_t        s1_dec, s2;
  logic        s2_vld;

  lock_state_t state, state_nxt;
  logic [7:0]  good_cnt, bad_cnt;

  logic                     hdr_err_d, chk_err_d, acc_d, trk_clr;
  logic [NUM_CH-1:0]        acc_v, seq_err_v;
  logic [NUM_CH-1:0]        ch_vld_q;
  logic [NUM_CH-1:0][31:0]  ch_data_q;
  logic                     hdr_err_q, chk_err_q, seq_err_q;
  logic [15:0]              err_cnt_q;

  assign s2_vld = vld_pipe[2];

  // ---------------- S1: decode ----------------
  always_comb begin
    s1_dec         = '0;
    s1_dec.hdr_ok  = (s1_word[SYNC_MSB:SYNC_LSB] == SYNC_BYTE) &&
                     (s1_word[RSV_MSB:RSV_LSB] == '0);
    s1_dec.ch      = s1_word[CH_MSB:CH_LSB];
    s1_dec.seq     = s1_word[SEQ_MSB:SEQ_LSB];
    s1_dec.payload = s1_word[PL_MSB:PL_LSB];
`ifdef UP_DEMUX_CHKSUM_EN
    s1_dec.chk_ok  = (s1_word[CHK_MSB:CHK_LSB] == payload_xor(s1_word[PL_MSB:PL_LSB]));
`else
    s1_dec.chk_ok  = 1'b1;
`endif
  end

`ifndef UP_DEMUX_CHKSUM_EN
  logic [7:0] unused_chk;
  assign unused_chk = s1_word[CHK_MSB:CHK_LSB];
`endif

  always_ff @(posedge fifo_rdclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_word  <= '0;
      s2       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], data_valid};
      if (data_valid)  s1_word <= up_data;
      if (vld_pipe[1]) s2      <= s1_dec;
    end
  end

  // ---------------- S2: lock FSM ----------------
  always_ff @(posedge fifo_rdclk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (s2_vld) begin
      unique case (state)
        HUNT:    if (s2.hdr_ok && (good_cnt + 8'd1 >= LG)) state_nxt = LOCKED;
        LOCKED:  if (!s2.hdr_ok && (bad_cnt + 8'd1 >= LB)) state_nxt = HUNT;
        default: ;
      endcase
    end
  end

  // Nothing is delivered or flagged while hunting.
  always_comb begin
    hdr_err_d = s2_vld && (state == LOCKED) && !s2.hdr_ok;
    chk_err_d = s2_vld && (state == LOCKED) && s2.hdr_ok && !s2.chk_ok;
    acc_d     = s2_vld && (state == LOCKED) && s2.hdr_ok && s2.chk_ok;
    trk_clr   = s2_vld && (state == HUNT) && (state_nxt == LOCKED);
    acc_v     = '0;
    for (int i = 0; i < NUM_CH; i++)
      acc_v[i] = acc_d && (s2.ch == ch_id_t'(i));
  end

  always_ff @(posedge fifo_rdclk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (s2_vld) begin
      if (state == HUNT) begin
        good_cnt <= (!s2.hdr_ok || state_nxt == LOCKED) ? 8'd0 : good_cnt + 8'd1;
        bad_cnt  <= '0;
      end else begin
        good_cnt <= '0;
        bad_cnt  <= (s2.hdr_ok || state_nxt == HUNT) ? 8'd0 : bad_cnt + 8'd1;
      end
    end
  end

  // ---------------- S2: per-channel sequence trackers ----------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_trk
    up_seq_tracker u_trk (
      .fifo_rdclk (fifo_rdclk),
      .rst_n      (rst_n),
      .acc        (acc_v[i]),
      .clr        (trk_clr),
      .seq        (s2.seq),
      .seq_err    (seq_err_v[i])
    );
  end

  // ---------------- S2: output registers ----------------
  always_ff @(posedge fifo_rdclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_vld_q  <= '0;
      ch_data_q <= '0;
      hdr_err_q <= 1'b0;
      chk_err_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_vld_q[i] <= acc_v[i];
        if (acc_v[i]) ch_data_q[i] <= s2.payload;
      end
      hdr_err_q <= hdr_err_d;
      chk_err_q <= chk_err_d;
      seq_err_q <= |seq_err_v;
      if ((hdr_err_d || chk_err_d || (|seq_err_v)) && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign {ch4_valid, ch3_valid, ch2_valid, ch1_valid} = ch_vld_q;
  assign ch1_data  = ch_data_q[0];
  assign ch2_data  = ch_data_q[1];
  assign ch3_data  = ch_data_q[2];
  assign ch4_data  = ch_data_q[3];
  assign sync_lock = (state == LOCKED);
  assign hdr_err   = hdr_err_q;
  assign chk_err   = chk_err_q;
  assign seq_err   = seq_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
